// File: rtl/seg_capture_if.sv
// Segment-line and captured-frame signals between a multiplexed 7-segment
// display driver (master) and the seg_capture block (slave).
interface seg_capture_if;
   logic        SEGA, SEGB, SEGC, SEGD, SEGE, SEGF, SEGG, SEGDP;
   logic [4:0]  SEGCAT;
   logic [19:0] DIGITS;
   logic [4:0]  DP;
   logic        FRAME_VALID;
   logic        ERROR;
   logic        TIMEOUT;

   modport master (
      output SEGA, SEGB, SEGC, SEGD, SEGE, SEGF, SEGG, SEGDP, SEGCAT,
      input  DIGITS, DP, FRAME_VALID, ERROR, TIMEOUT
   );

   modport slave (
      input  SEGA, SEGB, SEGC, SEGD, SEGE, SEGF, SEGG, SEGDP, SEGCAT,
      output DIGITS, DP, FRAME_VALID, ERROR, TIMEOUT
   );
endinterface

// File: rtl/seg_capture.sv
// Snoops a 5-digit multiplexed 7-segment display and reassembles complete
// BCD frames once each digit has dwelt stably for STABLE_CYCLES samples.
module seg_capture #(
   parameter int STABLE_CYCLES = 16,
   parameter int FRAME_TIMEOUT = 1_000_000
) (
   input logic          SYSCLK,
   input logic          RESET,
   seg_capture_if.slave bus
);
   localparam logic [7:0]  SC_MAX = 8'(STABLE_CYCLES);
   localparam logic [23:0] TO_MAX = 24'(FRAME_TIMEOUT);

   typedef enum logic {HUNT, COLLECT} state_t;

   // sample layout: {cat[4:0], a, b, c, d, e, f, g, dp}
   logic [12:0]      sync1, sync2, prev;
   logic [7:0]       sc;
   logic [23:0]      idle_cnt;
   logic [4:0]       cat;
   logic             onehot, stable, cap;
   logic [2:0]       idx;
   logic             dig_ok;
   logic [3:0]       dig_val;
   state_t           state;
   logic [2:0]       exp_idx, last_idx;
   logic [3:0][3:0]  shadow_d;
   logic [3:0]       shadow_dp;
   logic [19:0]      digits_r;
   logic [4:0]       dp_r;
   logic             fv_r, err_r;

   assign cat    = sync2[12:8];
   assign onehot = (cat != 5'd0) && ((cat & (cat - 5'd1)) == 5'd0);
   assign stable = (sync2 == prev) && onehot;
   assign cap    = stable && (sc == SC_MAX - 8'd1);

   always_comb begin
      idx = 3'd0;
      for (int i = 0; i < 5; i++)
         if (cat[i]) idx = 3'(i);
   end

   always_comb begin
      dig_ok  = 1'b1;
      dig_val = 4'd0;
      case (sync2[7:1])
         7'h7E:   dig_val = 4'd0;
         7'h30:   dig_val = 4'd1;
         7'h6D:   dig_val = 4'd2;
         7'h79:   dig_val = 4'd3;
         7'h33:   dig_val = 4'd4;
         7'h5B:   dig_val = 4'd5;
         7'h5F:   dig_val = 4'd6;
         7'h70:   dig_val = 4'd7;
         7'h7F:   dig_val = 4'd8;
         7'h7B:   dig_val = 4'd9;
         default: dig_ok  = 1'b0;
      endcase
   end

   // sc saturates, so a long dwell captures exactly once
   always_ff @(posedge SYSCLK) begin
      if (RESET) begin
         sync1    <= '0;
         sync2    <= '0;
         prev     <= '0;
         sc       <= '0;
         idle_cnt <= '0;
      end else begin
         sync1 <= {bus.SEGCAT, bus.SEGA, bus.SEGB, bus.SEGC, bus.SEGD,
                   bus.SEGE, bus.SEGF, bus.SEGG, bus.SEGDP};
         sync2 <= sync1;
         prev  <= sync2;
         if (!stable)           sc <= '0;
         else if (sc != SC_MAX) sc <= sc + 8'd1;
         if (cap)                     idle_cnt <= '0;
         else if (idle_cnt != TO_MAX) idle_cnt <= idle_cnt + 24'd1;
      end
   end

   always_ff @(posedge SYSCLK) begin
      if (RESET) begin
         state     <= HUNT;
         exp_idx   <= '0;
         last_idx  <= '0;
         shadow_d  <= '0;
         shadow_dp <= '0;
         digits_r  <= '0;
         dp_r      <= '0;
         fv_r      <= 1'b0;
         err_r     <= 1'b0;
      end else begin
         fv_r  <= 1'b0;
         err_r <= 1'b0;
         if (cap) begin
            case (state)
               HUNT: if (dig_ok && idx == 3'd0) begin
                  shadow_d[0]  <= dig_val;
                  shadow_dp[0] <= sync2[0];
                  last_idx     <= 3'd0;
                  exp_idx      <= 3'd1;
                  state        <= COLLECT;
               end
               COLLECT: begin
                  if (!dig_ok) begin
                     err_r <= 1'b1;
                     state <= HUNT;
                  end else if (idx == exp_idx && exp_idx == 3'd4) begin
                     digits_r <= {dig_val, shadow_d};
                     dp_r     <= {sync2[0], shadow_dp};
                     fv_r     <= 1'b1;
                     state    <= HUNT;
                  end else if (idx == exp_idx) begin
                     shadow_d[idx[1:0]]  <= dig_val;
                     shadow_dp[idx[1:0]] <= sync2[0];
                     last_idx            <= exp_idx;
                     exp_idx             <= exp_idx + 3'd1;
                  end else if (idx == last_idx) begin
                     // segments changed while the same cathode stayed on
                     shadow_d[idx[1:0]]  <= dig_val;
                     shadow_dp[idx[1:0]] <= sync2[0];
                  end else if (idx == 3'd0) begin
                     err_r        <= 1'b1;
                     shadow_d[0]  <= dig_val;
                     shadow_dp[0] <= sync2[0];
                     last_idx     <= 3'd0;
                     exp_idx      <= 3'd1;
                  end else begin
                     err_r <= 1'b1;
                     state <= HUNT;
                  end
               end
               default: state <= HUNT;
            endcase
         end else if (idle_cnt == TO_MAX - 24'd1) begin
            state <= HUNT;
         end
      end
   end

   assign bus.DIGITS      = digits_r;
   assign bus.DP          = dp_r;
   assign bus.FRAME_VALID = fv_r;
   assign bus.ERROR       = err_r;
   assign bus.TIMEOUT     = (idle_cnt == TO_MAX);
endmodule

// File: doc/seg_capture.md
SEG_CAPTURE -- requirements
Module: seg_capture

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 16, the number of consecutive identical samples required before a digit is captured (range 2..255).
REQ-002 The block SHALL have parameter FRAME_TIMEOUT, default 1_000_000, the number of cycles without a capture after which TIMEOUT asserts (range 16..2^24-1).
REQ-003 SYSCLK  input  1  single clock; all logic on rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 SEGA..SEGG  input  1 each  segment lines, active-high (1 = lit), asynchronous to SYSCLK.
REQ-006 SEGDP  input  1  decimal-point line, active-high.
REQ-007 SEGCAT  input  5  cathode select, active-high one-hot; bit i selects digit i.
REQ-008 DIGITS  output  20  last complete frame, BCD; digit i in bits [4i+3:4i].
REQ-009 DP  output  5  last complete frame's decimal points; bit i from digit i.
REQ-010 FRAME_VALID  output  1  one-cycle pulse when DIGITS/DP update.
REQ-011 ERROR  output  1  one-cycle pulse on a protocol or decode error.
REQ-012 TIMEOUT  output  1  level; high while no capture has occurred for FRAME_TIMEOUT cycles.

Function
REQ-013 All 13 inputs SHALL pass through a two-flop synchronizer; sample S = synchronized {SEGCAT, SEGA..SEGG, SEGDP}; P = S delayed one cycle.
REQ-014 Stability counter SC SHALL clear when S != P or synchronized SEGCAT is not one-hot (zero or multiple bits), otherwise increment, saturating at STABLE_CYCLES.
REQ-015 A capture SHALL occur on the edge where SC goes from STABLE_CYCLES-1 to STABLE_CYCLES, exactly once per stable dwell; index = bit position of SEGCAT.
REQ-016 Decode of {a..g} as hex SHALL be 7E=0, 30=1, 6D=2, 79=3, 33=4, 5B=5, 5F=6, 70=7, 7F=8, 7B=9; any other pattern is invalid.
REQ-017 Frame FSM states SHALL be HUNT and COLLECT, with expected index E (3 bits) and last-captured index L.
REQ-018 HUNT: a valid capture with index 0 SHALL store it in a shadow register, set L=0, E=1, and go to COLLECT; any other capture is ignored without ERROR.
REQ-019 COLLECT, valid capture with index == E SHALL store to shadow, set L=E, E=E+1.
REQ-020 COLLECT, valid capture with index == L (segments changed mid-dwell) SHALL overwrite that shadow slot without ERROR or state change.
REQ-021 COLLECT, valid capture of index 0 != L SHALL pulse ERROR and restart: shadow slot 0 written, L=0, E=1, stay in COLLECT.
REQ-022 COLLECT, any other index SHALL pulse ERROR and go to HUNT.
REQ-023 An invalid pattern captured in COLLECT SHALL pulse ERROR and go to HUNT; in HUNT it is ignored; shadow is never written with an invalid pattern.
REQ-024 Valid capture of index 4 with E == 4 SHALL, on the same edge, load DIGITS/DP from shadow plus the new digit, pulse FRAME_VALID, and go to HUNT.
REQ-025 DIGITS/DP SHALL change only on FRAME_VALID; partial frames never reach outputs.
REQ-026 Latency: with input change first sampled at edge N and held, FRAME_VALID SHALL be high for the one cycle after edge N+2+STABLE_CYCLES.
REQ-027 An idle counter SHALL clear on every capture (valid or invalid), else increment saturating; TIMEOUT SHALL be high while it equals FRAME_TIMEOUT; on first reaching it the FSM SHALL go to HUNT without ERROR.

Reset
REQ-028 RESET SHALL set DIGITS=0, DP=0, FRAME_VALID=0, ERROR=0, TIMEOUT=0, FSM=HUNT, SC=0, idle counter=0, shadow=0, synchronizer flops=0.
REQ-029 RESET mid-frame SHALL discard the partial frame; the next FRAME_VALID requires a full 0..4 sequence after release.

Verification (STABLE_CYCLES=4, FRAME_TIMEOUT=200)
REQ-030 Cathodes 0..4 held 10 cycles each showing 1,2,3,4,5, DP on 1 and 3 -> DIGITS=20'h54321, DP=5'b01010, one FRAME_VALID pulse 6 cycles after digit 4 first sampled.
REQ-031 Digit 2 pattern changes 3->7 mid-dwell (both stable >=5 cycles) -> no ERROR; DIGITS=20'h54721.
REQ-032 Sequence 0,1,3 -> ERROR pulse at index 3 capture, no FRAME_VALID; subsequent clean 0..4 frame of 9,8,7,6,5 -> DIGITS=20'h56789.
REQ-033 Pattern 7'h00 on cathode 2 during COLLECT -> ERROR pulse, DIGITS unchanged, FSM returns to HUNT.
REQ-034 Inputs frozen with SEGCAT=0 for 250 cycles -> TIMEOUT high from 200 cycles after last capture; drops on the edge of the next capture.
REQ-035 Each dwell held only 3 cycles (glitch) -> no capture, no FRAME_VALID, no ERROR; RESET asserted after cathode 2 -> all outputs 0, next full frame required.
